// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - CPU-to-slave bus sequencer with region wait states and ready timeout
module bus_sequencer #(
  parameter int WAIT_RAM    = 0,
  parameter int WAIT_PERIPH = 1,
  parameter int WAIT_DPRAM  = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [31:0]  mem_addr,
  input  logic         mem_rstrb,
  input  logic [3:0]   mem_wmask,
  input  logic [223:0] rdata_bus,
  input  logic         per_ready,
  output logic [6:0]   cs,
  output logic         per_rd,
  output logic         per_wr,
  output logic [31:0]  mem_rdata,
  output logic         mem_rbusy,
  output logic         mem_wbusy,
  output logic         bus_err
);

  localparam int WMAX_A = (WAIT_RAM > WAIT_PERIPH) ? WAIT_RAM : WAIT_PERIPH;
  localparam int WMAX   = (WMAX_A > WAIT_DPRAM) ? WMAX_A : WAIT_DPRAM;
  localparam int WW     = $clog2(WMAX + 2);
  localparam int TW     = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t         r_state;
  logic [6:0]     r_cs;
  logic           r_rd;
  logic           r_wr;
  logic [31:0]    r_rdata;
  logic           r_rbusy;
  logic           r_wbusy;
  logic           r_err;
  logic [WW-1:0]  r_wcnt;
  logic [TW-1:0]  r_tcnt;

  logic           w_req;
  logic           w_wr;
  logic [6:0]     w_cs;
  logic [WW-1:0]  w_wait;
  logic [31:0]    w_rdata;
  logic           w_unused_addr_lo;

  assign w_wr             = |mem_wmask;
  assign w_req            = mem_rstrb | w_wr;
  assign w_unused_addr_lo = ^mem_addr[15:0];

  // Region decode of the upper address half into chip select and wait count
  always_comb begin
    w_cs   = 7'b0000001;
    w_wait = WW'(WAIT_RAM);
    case (mem_addr[31:16])
      16'h0040: begin w_cs = 7'b0100000; w_wait = WW'(WAIT_PERIPH); end
      16'h0041: begin w_cs = 7'b0010000; w_wait = WW'(WAIT_PERIPH); end
      16'h0042: begin w_cs = 7'b0001000; w_wait = WW'(WAIT_PERIPH); end
      16'h0043: begin w_cs = 7'b0000100; w_wait = WW'(WAIT_PERIPH); end
      16'h0044: begin w_cs = 7'b0000010; w_wait = WW'(WAIT_PERIPH); end
      16'h0045: begin w_cs = 7'b1000000; w_wait = WW'(WAIT_DPRAM); end
      default:  begin w_cs = 7'b0000001; w_wait = WW'(WAIT_RAM); end
    endcase
  end

  // Pick the read word of the slave currently selected (cs is one-hot)
  always_comb begin
    w_rdata = 32'h0;
    for (int i = 0; i < 7; i++) begin
      if (r_cs[i]) w_rdata = w_rdata | rdata_bus[32*i +: 32];
    end
  end

  // Sequencer FSM: accept in IDLE/DONE, wait-count then poll ready in WAIT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cs    <= 7'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_rdata <= 32'h0;
      r_rbusy <= 1'b0;
      r_wbusy <= 1'b0;
      r_err   <= 1'b0;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_req) begin
            // a write mask wins over a coincident read strobe
            r_state <= S_WAIT;
            r_cs    <= w_cs;
            r_wr    <= w_wr;
            r_rd    <= ~w_wr;
            r_wbusy <= w_wr;
            r_rbusy <= ~w_wr;
            r_wcnt  <= w_wait;
            r_tcnt  <= '0;
          end else begin
            r_state <= S_IDLE;
            r_cs    <= 7'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rbusy <= 1'b0;
            r_wbusy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - 1'b1;
          end else if (per_ready || (r_tcnt == TW'(TIMEOUT - 1))) begin
            if (!per_ready) begin
              r_rdata <= 32'h0;
              r_err   <= 1'b1;
            end else if (r_rd) begin
              r_rdata <= w_rdata;
            end
            r_state <= S_DONE;
            r_cs    <= 7'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rbusy <= 1'b0;
            r_wbusy <= 1'b0;
            r_tcnt  <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cs        = r_cs;
  assign per_rd    = r_rd;
  assign per_wr    = r_wr;
  assign mem_rdata = r_rdata;
  assign mem_rbusy = r_rbusy;
  assign mem_wbusy = r_wbusy;
  assign bus_err   = r_err;

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter WAIT_RAM, default 0: extra wait cycles for RAM region.
REQ-002 SHALL have parameter WAIT_PERIPH, default 1: extra wait cycles for uart/gpio/mult/div/bin_to_bcd regions.
REQ-003 SHALL have parameter WAIT_DPRAM, default 1: extra wait cycles for dpRAM region.
REQ-004 SHALL have parameter TIMEOUT, default 15: max cycles waiting on per_ready after wait count expires.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge system clock.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 mem_addr  input  32  CPU byte address.
REQ-009 mem_rstrb  input  1  CPU read strobe, one-cycle pulse.
REQ-010 mem_wmask  input  4  CPU byte write mask; nonzero = write request.
REQ-011 rdata_bus  input  224  seven 32-bit slave read words, slot i = bits [32i+31:32i], slot index = cs bit index.
REQ-012 per_ready  input  1  selected slave ready/ack.
REQ-013 cs  output  7  one-hot chip select: bit6 dpRAM, 5 uart, 4 gpio, 3 mult, 2 div, 1 bin_to_bcd, 0 RAM.
REQ-014 per_rd / per_wr  output  1 each  registered read/write command qualifiers to selected slave.
REQ-015 mem_rdata  output  32  registered read data to CPU.
REQ-016 mem_rbusy / mem_wbusy  output  1 each  read/write stall to CPU.
REQ-017 bus_err  output  1  sticky timeout flag.

Function
REQ-018 Region decode on mem_addr[31:16]: 0x0040 uart, 0x0041 gpio, 0x0042 mult, 0x0043 div, 0x0044 bin_to_bcd, 0x0045 dpRAM, anything else RAM.
REQ-019 States: IDLE, WAIT, DONE.
REQ-020 IDLE/DONE: request = mem_rstrb or |mem_wmask; on request latch decoded cs, direction, load wait counter with region WAIT_*, go WAIT next edge.
REQ-021 Simultaneous mem_rstrb and nonzero mem_wmask: write SHALL win; read dropped.
REQ-022 WAIT: cs, per_rd/per_wr held constant; wait counter decrements to 0; then per_ready sampled each cycle, timeout counter increments.
REQ-023 WAIT with counter==0 and per_ready=1: read captures rdata_bus slot of active cs into mem_rdata; go DONE.
REQ-024 Timeout counter reaching TIMEOUT without per_ready: mem_rdata=32'h0, bus_err set, go DONE.
REQ-025 DONE lasts one cycle unless a new request arrives (REQ-020); otherwise IDLE; cs=0 in IDLE.
REQ-026 mem_rbusy=1 in WAIT for reads only; mem_wbusy=1 in WAIT for writes only; both 0 in IDLE/DONE.
REQ-027 Minimum latency: request edge -> DONE, i.e. WAIT_x + 1 cycles with per_ready tied high; mem_rdata valid from first DONE cycle until next read capture.
REQ-028 Requests arriving in WAIT SHALL be ignored.
REQ-029 bus_err cleared only by reset.
REQ-030 Counters sized for max(WAIT_*) and TIMEOUT; no wrap during a transaction.

Reset
REQ-031 resetn low SHALL immediately force IDLE, cs=0, per_rd=per_wr=0, mem_rbusy=mem_wbusy=0, mem_rdata=0, bus_err=0, counters 0, including mid-transaction; in-flight access abandoned.
REQ-032 First request accepted on first rising edge with resetn high.

Verification
REQ-033 Read 0x00000010, per_ready=1, RAM slot=0x12345678 -> cs=0000001, rbusy 1 cycle, mem_rdata=0x12345678.
REQ-034 Write 0x00410000 wmask=1111, per_ready=1 -> cs=0010000, per_wr=1, wbusy 2 cycles (WAIT_PERIPH=1), bus_err=0.
REQ-035 Read 0x00450004, per_ready held 0 -> after 1+TIMEOUT WAIT cycles mem_rdata=0, bus_err=1 and stays 1 on next good read.
REQ-036 rstrb and wmask=0011 same cycle at 0x00420000 -> write only, cs=0001000, per_rd=0, mem_rbusy=0.
REQ-037 resetn pulsed low during WAIT of uart read -> all outputs 0 asynchronously; new read after release completes normally.
REQ-038 Back-to-back read issued in DONE cycle at 0x00430000 -> accepted without IDLE cycle, cs=0000100.
